// File: rtl/lim_pkg.sv
// Shared types and funct-register field positions for the LiM range sequencer.
package lim_pkg;

  // Sequencer states: idle, bank request pending, bank access in flight, core response.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lim_state_e;

  // Read-data reduction applied across the words of a range load.
  typedef enum logic [1:0] {
    RED_NONE = 2'b00,
    RED_OR   = 2'b01,
    RED_AND  = 2'b10,
    RED_XOR  = 2'b11
  } lim_reduce_e;

  // Funct register field layout; the count field runs from FUNCT_CNT_LSB to the MSB.
  localparam int unsigned FUNCT_OPC_LSB    = 0;
  localparam int unsigned OPCODE_W         = 3;
  localparam int unsigned FUNCT_STRIDE_LSB = 3;
  localparam int unsigned STRIDE_W         = 2;
  localparam int unsigned FUNCT_RED_LSB    = 5;
  localparam int unsigned FUNCT_RED_W      = 2;
  localparam int unsigned FUNCT_CNT_LSB    = 7;

endpackage

// File: rtl/lim_reduce_acc.sv
// Combinational fold of one bank read word into the range accumulator.
module lim_reduce_acc
  import lim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  lim_reduce_e           reduce_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] fold_o
);

  // Select the fold; "none" simply captures the latest word.
  always_comb begin
    fold_o = rdata_i;
    case (reduce_i)
      RED_NONE: fold_o = rdata_i;
      RED_OR:   fold_o = acc_i | rdata_i;
      RED_AND:  fold_o = acc_i & rdata_i;
      RED_XOR:  fold_o = acc_i ^ rdata_i;
      default:  fold_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lim_range_sequencer.sv
// Core data-port front end for a req/gnt/rvalid logic-in-memory bank.
// Holds the LiM funct register and turns one core access into a strided
// sequence of single-word bank accesses, optionally reducing the read data.
module lim_range_sequencer
  import lim_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 20,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] FUNCT_ADDR = 20'hFFFFC
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [OPCODE_W-1:0]     mem_opcode_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned CNT_W = DATA_WIDTH - FUNCT_CNT_LSB;

  // Byte-enable merge used for partial writes of the funct register.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [BYTES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  lim_state_e              state_r;
  lim_state_e              state_next_s;
  logic [DATA_WIDTH-1:0]   funct_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    we_r;
  logic [BYTES-1:0]        be_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [OPCODE_W-1:0]     opcode_r;
  logic [STRIDE_W-1:0]     stride_r;
  lim_reduce_e             reduce_r;
  logic [CNT_W-1:0]        remaining_r;
  logic [DATA_WIDTH-1:0]   acc_r;
  logic [DATA_WIDTH-1:0]   rdata_r;

  logic [ADDR_WIDTH-1:0]   aligned_addr_s;
  logic                    funct_hit_s;
  logic                    grant_s;
  logic [CNT_W-1:0]        count_s;
  logic                    range_s;
  lim_reduce_e             funct_red_s;
  logic [DATA_WIDTH-1:0]   acc_init_s;
  logic                    done_s;
  logic                    last_s;
  logic [DATA_WIDTH-1:0]   fold_s;
  logic [ADDR_WIDTH-1:0]   stride_bytes_s;
  logic                    unused_s;

  assign aligned_addr_s = {data_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_s       = ^data_addr_i[OFF_W-1:0];
  assign funct_hit_s    = (aligned_addr_s == FUNCT_ADDR);
  assign grant_s        = (state_r == ST_IDLE) && data_req_i;
  assign count_s        = funct_r[DATA_WIDTH-1:FUNCT_CNT_LSB];
  assign range_s        = (count_s >= CNT_W'(2));
  assign funct_red_s    = lim_reduce_e'(funct_r[FUNCT_RED_LSB +: FUNCT_RED_W]);
  assign last_s         = (remaining_r == CNT_W'(1));
  assign stride_bytes_s = ADDR_WIDTH'(BYTES) << stride_r;
  // A bank word completes in WAIT, or already in ISSUE when gnt and rvalid coincide.
  assign done_s         = ((state_r == ST_WAIT) && mem_rvalid_i) ||
                          ((state_r == ST_ISSUE) && mem_gnt_i && mem_rvalid_i);

  // Accumulator seed: AND starts from all ones, the others from zero.
  always_comb begin
    acc_init_s = {DATA_WIDTH{1'b0}};
    if (funct_red_s == RED_AND) begin
      acc_init_s = {DATA_WIDTH{1'b1}};
    end else begin
      acc_init_s = {DATA_WIDTH{1'b0}};
    end
  end

  lim_reduce_acc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reduce (
    .reduce_i(reduce_r),
    .acc_i   (acc_r),
    .rdata_i (mem_rdata_i),
    .fold_o  (fold_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (data_req_i) begin
          state_next_s = funct_hit_s ? ST_RESP : ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_gnt_i && mem_rvalid_i) begin
          state_next_s = last_s ? ST_RESP : ST_ISSUE;
        end else if (mem_gnt_i) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          state_next_s = last_s ? ST_RESP : ST_ISSUE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output decode; the core grant is combinational and only offered in IDLE.
  always_comb begin
    data_gnt_o    = 1'b0;
    mem_req_o     = 1'b0;
    data_rvalid_o = 1'b0;
    busy_o        = 1'b1;
    case (state_r)
      ST_IDLE: begin
        data_gnt_o = data_req_i & ~rst_i;
        busy_o     = 1'b0;
      end
      ST_ISSUE: mem_req_o     = 1'b1;
      ST_WAIT:  busy_o        = 1'b1;
      ST_RESP:  data_rvalid_o = 1'b1;
      default:  busy_o        = 1'b0;
    endcase
  end

  // Funct register: written only by a granted store to its address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      funct_r <= {DATA_WIDTH{1'b0}};
    end else if (grant_s && funct_hit_s && data_we_i) begin
      funct_r <= merge_bytes(funct_r, data_wdata_i, data_be_i);
    end else begin
      funct_r <= funct_r;
    end
  end

  // Transfer datapath: latch the request and funct fields at grant, step per bank word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_r      <= {ADDR_WIDTH{1'b0}};
      we_r        <= 1'b0;
      be_r        <= {BYTES{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
      opcode_r    <= {OPCODE_W{1'b0}};
      stride_r    <= {STRIDE_W{1'b0}};
      reduce_r    <= RED_NONE;
      remaining_r <= {CNT_W{1'b0}};
      acc_r       <= {DATA_WIDTH{1'b0}};
      rdata_r     <= {DATA_WIDTH{1'b0}};
    end else if (grant_s) begin
      addr_r      <= aligned_addr_s;
      we_r        <= data_we_i;
      be_r        <= range_s ? {BYTES{1'b1}} : data_be_i;
      wdata_r     <= data_wdata_i;
      opcode_r    <= funct_r[FUNCT_OPC_LSB +: OPCODE_W];
      stride_r    <= funct_r[FUNCT_STRIDE_LSB +: STRIDE_W];
      reduce_r    <= funct_red_s;
      remaining_r <= range_s ? count_s : CNT_W'(1);
      acc_r       <= acc_init_s;
      if (funct_hit_s) begin
        rdata_r <= data_we_i ? {DATA_WIDTH{1'b0}} : funct_r;
      end else begin
        rdata_r <= rdata_r;
      end
    end else if (done_s) begin
      acc_r <= we_r ? acc_r : fold_s;
      if (last_s) begin
        rdata_r <= we_r ? mem_rdata_i : fold_s;
      end else begin
        remaining_r <= remaining_r - CNT_W'(1);
        addr_r      <= addr_r + stride_bytes_s;
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  assign mem_addr_o   = addr_r;
  assign mem_we_o     = we_r;
  assign mem_be_o     = be_r;
  assign mem_wdata_o  = wdata_r;
  assign mem_opcode_o = opcode_r;
  assign data_rdata_o = rdata_r;

endmodule

// File: tb/tb_lim_range_sequencer.sv
// Directed self-checking bench for lim_range_sequencer with a behavioural bank.
module tb_lim_range_sequencer;

  localparam logic [19:0] FUNCT_ADDR = 20'hFFFFC;

  logic        clk;
  logic        rst;
  logic        data_req;
  logic        data_gnt_o;
  logic [19:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_gnt;
  logic [19:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [2:0]  mem_opcode_o;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy_o;

  lim_range_sequencer #(
    .ADDR_WIDTH(20),
    .DATA_WIDTH(32),
    .FUNCT_ADDR(FUNCT_ADDR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_req_i   (data_req),
    .data_gnt_o   (data_gnt_o),
    .data_addr_i  (data_addr),
    .data_we_i    (data_we),
    .data_be_i    (data_be),
    .data_wdata_i (data_wdata),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_opcode_o (mem_opcode_o),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Bank model knobs and observations.
  int          gnt_lat;
  int          rv_lat;
  int          abort_acc;
  bit          hold_req;
  logic [31:0] bank_data [8];
  logic [19:0] seen_addr [8];
  logic [3:0]  seen_be   [8];
  logic        seen_we   [8];
  logic [2:0]  seen_op   [8];
  logic [31:0] seen_wd   [8];
  int          n_acc;
  int          viol_stable;
  int          viol_gnt;
  bit          aborted;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{data_gnt_o, data_rvalid_o, data_rdata_o, mem_req_o, mem_addr_o,
             mem_we_o, mem_be_o, mem_wdata_o, mem_opcode_o, busy_o};
  endfunction

  // One core transaction; the loop plays core and bank once per falling edge.
  task automatic run_txn(input logic [19:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input int exp_lat, input string tag);
    int cyc;
    int gcnt;
    int rcnt;
    bit outst;
    bit done;
    logic [19:0] h_addr;
    logic [31:0] h_wd;
    cyc = 0; gcnt = 0; rcnt = 0; outst = 1'b0; done = 1'b0;
    n_acc = 0; viol_stable = 0; viol_gnt = 0; aborted = 1'b0;
    h_addr = 20'h0; h_wd = 32'h0;
    @(negedge clk);
    data_req = 1'b1; data_addr = a; data_we = we; data_be = be; data_wdata = wd;
    #1;
    check_eq({tag, "_gnt"}, 64'(data_gnt_o), 64'd1);
    while (!done && !aborted && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (abort_acc > 0 && outst && n_acc == abort_acc) begin
        rst = 1'b1;
        #1;
        check_eq({tag, "_rst_outs"}, 64'(any_out()), 64'd0);
        aborted = 1'b1;
      end else begin
        if (hold_req && busy_o && !data_rvalid_o) begin
          data_req = 1'b1; data_addr = FUNCT_ADDR; data_we = 1'b0;
        end else begin
          data_req = 1'b0;
        end
        #1;
        if (data_gnt_o) viol_gnt++;
        if (data_rvalid_o) begin
          done = 1'b1;
          check_eq({tag, "_rdata"}, 64'(data_rdata_o), 64'(exp_rd));
          check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        end
        if (outst) begin
          if (rcnt == rv_lat) begin
            mem_rvalid = 1'b1;
            mem_rdata = bank_data[(n_acc - 1) % 8];
            outst = 1'b0;
          end else begin
            rcnt++;
          end
        end else if (mem_req_o) begin
          if (gcnt == 0) begin
            h_addr = mem_addr_o; h_wd = mem_wdata_o;
          end else if (mem_addr_o !== h_addr || mem_wdata_o !== h_wd) begin
            viol_stable++;
          end
          if (gcnt == gnt_lat) begin
            mem_gnt = 1'b1;
            if (n_acc < 8) begin
              seen_addr[n_acc] = mem_addr_o; seen_be[n_acc] = mem_be_o;
              seen_we[n_acc] = mem_we_o; seen_op[n_acc] = mem_opcode_o;
              seen_wd[n_acc] = mem_wdata_o;
            end
            n_acc++;
            outst = 1'b1; rcnt = 0; gcnt = 0;
          end else begin
            gcnt++;
          end
        end else if (gcnt != 0) begin
          viol_stable++;
        end
      end
    end
    if (!aborted) begin
      check_eq({tag, "_done"}, 64'(done), 64'd1);
      check_eq({tag, "_stable"}, 64'(viol_stable), 64'd0);
      check_eq({tag, "_gnt_busy"}, 64'(viol_gnt), 64'd0);
      @(negedge clk);
      #1;
      check_eq({tag, "_pulse"}, 64'(data_rvalid_o), 64'd0);
      check_eq({tag, "_hold"}, 64'(data_rdata_o), 64'(exp_rd));
      check_eq({tag, "_idle"}, 64'(busy_o), 64'd0);
    end
  endtask

  task automatic write_funct(input logic [31:0] v, input string tag);
    run_txn(FUNCT_ADDR, 1'b1, 4'hF, v, 32'h0, 1, tag);
    check_eq({tag, "_nacc"}, 64'(n_acc), 64'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; data_req = 1'b0; data_addr = 20'h0; data_we = 1'b0; data_be = 4'h0;
    data_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    gnt_lat = 0; rv_lat = 0; abort_acc = 0; hold_req = 1'b0;
    for (int i = 0; i < 8; i++) bank_data[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", 64'(any_out()), 64'd0);
    rst = 1'b0;

    // Funct register write, read, byte-enabled write, unaligned read.
    write_funct(32'h0000_0009, "t1_wr");
    run_txn(FUNCT_ADDR, 1'b0, 4'hF, 32'h0, 32'h0000_0009, 1, "t1_rd");
    check_eq("t1_rd_nacc", 64'(n_acc), 64'd0);
    run_txn(FUNCT_ADDR, 1'b1, 4'b0001, 32'hFFFF_FF05, 32'h0, 1, "t1_wrbe");
    run_txn(20'hFFFFE, 1'b0, 4'hF, 32'h0, 32'h0000_0005, 1, "t1_rdbe");

    // Single load with count 0: core byte enables, aligned address, opcode 101.
    bank_data[0] = 32'hDEAD_BEEF;
    run_txn(20'h00103, 1'b0, 4'b0011, 32'h0, 32'hDEAD_BEEF, 3, "t2");
    check_eq("t2_nacc", 64'(n_acc), 64'd1);
    check_eq("t2_addr", 64'(seen_addr[0]), 64'h00100);
    check_eq("t2_be", 64'(seen_be[0]), 64'h3);
    check_eq("t2_op", 64'(seen_op[0]), 64'h5);
    check_eq("t2_we", 64'(seen_we[0]), 64'h0);

    // Range OR load of 4 words, stride 1.
    write_funct(32'h0000_0222, "t3_cfg");
    bank_data[0] = 32'h1; bank_data[1] = 32'h2; bank_data[2] = 32'h4; bank_data[3] = 32'h8;
    run_txn(20'h30000, 1'b0, 4'b0001, 32'h0, 32'h0000_000F, 9, "t3");
    check_eq("t3_nacc", 64'(n_acc), 64'd4);
    check_eq("t3_a0", 64'(seen_addr[0]), 64'h30000);
    check_eq("t3_a1", 64'(seen_addr[1]), 64'h30004);
    check_eq("t3_a2", 64'(seen_addr[2]), 64'h30008);
    check_eq("t3_a3", 64'(seen_addr[3]), 64'h3000C);
    check_eq("t3_be", 64'(seen_be[2]), 64'hF);
    check_eq("t3_op", 64'(seen_op[3]), 64'h2);

    // Stride 4 words, count 3, XOR, wrapping past the top of the address space.
    write_funct(32'h0000_01F0, "t4_cfg");
    bank_data[0] = 32'hA; bank_data[1] = 32'h5; bank_data[2] = 32'hF;
    run_txn(20'hFFFE0, 1'b0, 4'hF, 32'h0, 32'h0, 7, "t4");
    check_eq("t4_nacc", 64'(n_acc), 64'd3);
    check_eq("t4_a0", 64'(seen_addr[0]), 64'hFFFE0);
    check_eq("t4_a1", 64'(seen_addr[1]), 64'hFFFF0);
    check_eq("t4_a2", 64'(seen_addr[2]), 64'h00000);

    // AND reduction over 2 words.
    write_funct(32'h0000_0140, "t5_cfg");
    bank_data[0] = 32'hF0F0_FFFF; bank_data[1] = 32'h0FF0_00FF;
    run_txn(20'h00500, 1'b0, 4'hF, 32'h0, 32'h00F0_00FF, 5, "t5");
    check_eq("t5_a1", 64'(seen_addr[1]), 64'h00504);

    // Backpressure on a single store: gnt held off 5 cycles, rvalid 3 cycles late.
    write_funct(32'h0, "t6_cfg");
    bank_data[0] = 32'hCAFE_0001;
    gnt_lat = 5; rv_lat = 3; hold_req = 1'b1;
    run_txn(20'h00208, 1'b1, 4'hF, 32'h1234_5678, 32'hCAFE_0001, 11, "t6");
    gnt_lat = 0; rv_lat = 0; hold_req = 1'b0;
    check_eq("t6_nacc", 64'(n_acc), 64'd1);
    check_eq("t6_addr", 64'(seen_addr[0]), 64'h00208);
    check_eq("t6_wd", 64'(seen_wd[0]), 64'h1234_5678);
    check_eq("t6_we", 64'(seen_we[0]), 64'h1);

    // Reset during the second access of a 4-word range.
    write_funct(32'h0000_0222, "t7_cfg");
    abort_acc = 2; rv_lat = 2;
    run_txn(20'h40000, 1'b0, 4'hF, 32'h0, 32'h0, 0, "t7");
    abort_acc = 0; rv_lat = 0;
    check_eq("t7_aborted", 64'(aborted), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      if (data_rvalid_o || busy_o || mem_req_o) cnt++;
    end
    check_eq("t7_late", 64'(cnt), 64'd0);
    run_txn(FUNCT_ADDR, 1'b0, 4'hF, 32'h0, 32'h0, 1, "t7_funct");
    check_eq("t7_funct_nacc", 64'(n_acc), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
